mtr_pwm_drv: RTL and testbench
==============================

# mtr_pwm_drv

Downstream consumer of the PID speed outputs: converts signed 11-bit `lft_spd`/`rght_spd` into H-bridge PWM drive (forward/reverse leg per motor). Samples the commanded speeds once per PWM period so duty changes are glitch-free. On a direction reversal it forces a both-legs-low interval so the bridge is never driven forward and reverse in the same cycle.

## Interface
- `PWM_W`, default 10: PWM counter width; period = 2^PWM_W clocks.
- `DEAD_PRDS`, default 1: full PWM periods of both-legs-low inserted on reversal (only with `MTR_DEADTIME_EN`).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: drive enable; low forces all legs low at the next period boundary.
- `lft_spd` in 11: signed left speed command (two's complement).
- `rght_spd` in 11: signed right speed command.
- `lft_fwd`, `lft_rev` out 1: left bridge leg drives.
- `rght_fwd`, `rght_rev` out 1: right bridge leg drives.
- `prd_strt` out 1: one-cycle pulse when the counter is 0.

## Operation
- Free-running `cnt` (PWM_W bits), increments every clock, wraps 2^PWM_W−1 → 0.
- Sample point: on the clock where cnt == 2^PWM_W−1, each side registers `en`, sign and magnitude of its speed; registered values take effect from cnt == 0.
- Magnitude: |spd|; −1024 clamps to 1023. Duty `d` = magnitude (10 bits).
- Active leg high while cnt < d; d = 0 → leg low all period; d = 1023 → low only on cnt == 1023.
- Per-side FSM (states IDLE, FWD, REV, DEAD), transitions only at sample point:
  - IDLE: both legs low. Sampled en=1 and d≠0 → FWD (sign 0) or REV (sign 1).
  - FWD: `*_fwd` = (cnt < d), `*_rev` = 0. Sampled en=0 or d=0 → IDLE. Sampled sign=1, d≠0 → DEAD (macro on) or REV (macro off).
  - REV: mirror of FWD.
  - DEAD: both legs low; period counter counts DEAD_PRDS boundaries, then → FWD/REV/IDLE per the sample taken at the final boundary.
- Direction memory: IDLE entered from FWD then REV requested → still goes via DEAD (last-driven direction is remembered until a DEAD interval or reset clears it).
- Invariant: `*_fwd` and `*_rev` of one side never high in the same cycle, any input sequence.
- Mid-period changes to `lft_spd`/`rght_spd`/`en` are ignored until the next sample point.

## Timing
- Reset: cnt = 0, all legs 0, `prd_strt` = 0, both FSMs IDLE, last-direction cleared, sampled duty 0. First `prd_strt` on the clock after `rst` deasserts with cnt = 0.
- Outputs are registered: leg value for counter value k appears one clock after cnt == k; `prd_strt` aligned with the leg output of cnt == 0.
- Command-to-drive latency: input held at sample point → effect starts at the next period's first output cycle (≤ 2^PWM_W + 1 clocks).
- `rst` asserted mid-period: all outputs low on the next clock, counter restarts at 0.
- `en` deassert: legs continue current duty to end of period, then low.

## Configuration
- `MTR_DEADTIME_EN` defined: reversal passes through DEAD for DEAD_PRDS periods.
- Undefined: DEAD state and its counter are compiled out; FWD↔REV switches directly at the sample point (legs mutually exclusive by construction, no gap beyond the boundary).

## Structure
- Package `mtr_pkg`: `PWM_W` default, `SPD_W` = 11, `mtr_state_t` enum {IDLE, FWD, REV, DEAD}, `SPD_MAG_MAX` = 1023.
- Sub-module `mtr_side`: one instance per motor (sampling, magnitude/clamp, FSM, leg compare); top holds shared counter and `prd_strt`.

## Test plan
- Reset then `en`=1, `lft_spd`=256: from first full period, `lft_fwd` high 256 of 1024 clocks, `lft_rev` always 0.
- `rght_spd`=−1024: `rght_rev` high 1023 clocks/period, low 1; `rght_fwd` 0.
- `lft_spd` 300 → −300 mid-period, macro on, DEAD_PRDS=1: current period finishes at 300 fwd, next period both low, following period `lft_rev` 300 clocks.
- Same with macro off: period after the change is `lft_rev` 300 clocks directly.
- `en` dropped at cnt=500 with spd=800: duty completes to cnt 799, all legs low from next period; `spd`=0 → IDLE, no pulses.
- `rst` asserted at cnt=600 for 1 clock: all legs 0 next clock, `prd_strt` 1 clock after release; random-stimulus check that fwd&rev never both high.

Source files
------------

// File: rtl/mtr_pkg.sv
// Shared types and constants for the H-bridge PWM motor driver.
package mtr_pkg;

    localparam int PWM_W_DFLT  = 10;
    localparam int SPD_W       = 11;
    localparam int DUTY_W      = SPD_W - 1;
    localparam int SPD_MAG_MAX = 1023;

    typedef enum logic [1:0] {IDLE, FWD, REV, DEAD} mtr_state_t;

endpackage

// File: rtl/mtr_side.sv
// One motor side: period-boundary command sampling, magnitude clamp, drive FSM and leg compare.
// Optional MTR_DEADTIME_EN routes every direction reversal through a both-legs-low DEAD interval.
module mtr_side
    import mtr_pkg::*;
#(
    parameter int PWM_W     = PWM_W_DFLT,
    parameter int DEAD_PRDS = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             smpl_i,
    input  logic [PWM_W-1:0] cnt_i,
    input  logic             en_i,
    input  logic [SPD_W-1:0] spd_i,
    output logic             fwd_o,
    output logic             rev_o
);

    if (DEAD_PRDS < 1) begin : g_dead_prds_chk
        $error("mtr_side: DEAD_PRDS must be at least 1");
    end

    // |spd| as a duty value; the most negative command would overflow, so clamp it.
    function automatic logic [DUTY_W-1:0] sat_mag(input logic [SPD_W-1:0] spd);
        logic [SPD_W-1:0] mag;
        mag = spd[SPD_W-1] ? (~spd + SPD_W'(1)) : spd;
        if (mag > SPD_W'(SPD_MAG_MAX)) begin
            return DUTY_W'(SPD_MAG_MAX);
        end
        return mag[DUTY_W-1:0];
    endfunction

    mtr_state_t        state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              fwd_q, fwd_d;
    logic              rev_q, rev_d;
    logic [DUTY_W-1:0] mag;
    logic              want_drv;
    logic              want_rev;

    assign mag      = sat_mag(spd_i);
    assign want_drv = en_i && (mag != '0);
    assign want_rev = spd_i[SPD_W-1];

`ifdef MTR_DEADTIME_EN
    localparam int DCNT_W = (DEAD_PRDS > 1) ? $clog2(DEAD_PRDS) : 1;

    logic              last_vld_q, last_vld_d;
    logic              last_rev_q, last_rev_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
`endif

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
`ifdef MTR_DEADTIME_EN
        last_vld_d = last_vld_q;
        last_rev_d = last_rev_q;
        dcnt_d     = dcnt_q;
`endif
        if (smpl_i) begin
            duty_d = mag;
`ifdef MTR_DEADTIME_EN
            // Leaving DEAD (to any state) forgets the last driven direction.
            if (state_q == DEAD && dcnt_q != DCNT_W'(DEAD_PRDS - 1)) begin
                dcnt_d = dcnt_q + DCNT_W'(1);
            end else if (!want_drv) begin
                state_d = IDLE;
                if (state_q == DEAD) begin
                    last_vld_d = 1'b0;
                end
            end else if (state_q != DEAD && last_vld_q && (last_rev_q != want_rev)) begin
                state_d = DEAD;
                dcnt_d  = '0;
            end else begin
                state_d    = want_rev ? REV : FWD;
                last_vld_d = 1'b1;
                last_rev_d = want_rev;
            end
`else
            if (!want_drv) begin
                state_d = IDLE;
            end else begin
                state_d = want_rev ? REV : FWD;
            end
`endif
        end
        fwd_d = (state_q == FWD) && (32'(cnt_i) < 32'(duty_q));
        rev_d = (state_q == REV) && (32'(cnt_i) < 32'(duty_q));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            duty_q  <= '0;
            fwd_q   <= 1'b0;
            rev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            fwd_q   <= fwd_d;
            rev_q   <= rev_d;
        end
    end

`ifdef MTR_DEADTIME_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_vld_q <= 1'b0;
            last_rev_q <= 1'b0;
            dcnt_q     <= '0;
        end else begin
            last_vld_q <= last_vld_d;
            last_rev_q <= last_rev_d;
            dcnt_q     <= dcnt_d;
        end
    end
`endif

    assign fwd_o = fwd_q;
    assign rev_o = rev_q;

endmodule

// File: rtl/mtr_pwm_drv.sv
// Dual H-bridge PWM driver: shared free-running period counter plus one mtr_side per motor.
// Define MTR_DEADTIME_EN to insert DEAD_PRDS both-legs-low periods on direction reversal.
module mtr_pwm_drv
    import mtr_pkg::*;
#(
    parameter int PWM_W     = PWM_W_DFLT,
    parameter int DEAD_PRDS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SPD_W-1:0] lft_spd,
    input  logic [SPD_W-1:0] rght_spd,
    output logic             lft_fwd,
    output logic             lft_rev,
    output logic             rght_fwd,
    output logic             rght_rev,
    output logic             prd_strt
);

    logic [PWM_W-1:0] cnt_q, cnt_d;
    logic             prd_strt_q, prd_strt_d;
    logic             smpl;

    // Commands are captured on the last count so they govern the whole next period.
    assign smpl = &cnt_q;

    always_comb begin
        cnt_d      = cnt_q + PWM_W'(1);
        prd_strt_d = (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            prd_strt_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            prd_strt_q <= prd_strt_d;
        end
    end

    mtr_side #(
        .PWM_W     (PWM_W),
        .DEAD_PRDS (DEAD_PRDS)
    ) u_lft (
        .clk_i  (clk),
        .rst_i  (rst),
        .smpl_i (smpl),
        .cnt_i  (cnt_q),
        .en_i   (en),
        .spd_i  (lft_spd),
        .fwd_o  (lft_fwd),
        .rev_o  (lft_rev)
    );

    mtr_side #(
        .PWM_W     (PWM_W),
        .DEAD_PRDS (DEAD_PRDS)
    ) u_rght (
        .clk_i  (clk),
        .rst_i  (rst),
        .smpl_i (smpl),
        .cnt_i  (cnt_q),
        .en_i   (en),
        .spd_i  (rght_spd),
        .fwd_o  (rght_fwd),
        .rev_o  (rght_rev)
    );

    assign prd_strt = prd_strt_q;

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Bench for mtr_pwm_drv: period-plan reference model checked every cycle, plus directed
// per-period high-count expectations. Honours MTR_DEADTIME_EN the same way as the design.
`timescale 1ns/1ps
module tb_mtr_pwm_drv;

    localparam int PWM_W     = 10;
    localparam int PRD       = 1 << PWM_W;
    localparam int DEAD_PRDS = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic signed [10:0] lft_spd  = '0;
    logic signed [10:0] rght_spd = '0;
    logic lft_fwd, lft_rev, rght_fwd, rght_rev, prd_strt;

    int n_chk  = 0;
    int n_pass = 0;

    mtr_pwm_drv #(.PWM_W(PWM_W), .DEAD_PRDS(DEAD_PRDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .lft_fwd  (lft_fwd),
        .lft_rev  (lft_rev),
        .rght_fwd (rght_fwd),
        .rght_rev (rght_rev),
        .prd_strt (prd_strt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: per side, a drive mode for the current period (0 off, 1 fwd, 2 rev,
    // 3 dead) and a duty; the output for count k is simply mode-leg AND (k < duty).
    int m_cnt;
    int m_mode[2];
    int m_duty[2];
    int m_last[2];
`ifdef MTR_DEADTIME_EN
    int m_dleft[2];
`endif
    int e_fwd[2];
    int e_rev[2];
    int e_prd;

    function automatic int mag_of(input int v);
        int m;
        m = (v < 0) ? -v : v;
        return (m > 1023) ? 1023 : m;
    endfunction

    task automatic plan(input int s, input int v);
        int m;
        int want;
        m    = mag_of(v);
        want = (en !== 1'b1 || m == 0) ? 0 : ((v < 0) ? 2 : 1);
`ifdef MTR_DEADTIME_EN
        if (m_mode[s] == 3) begin
            m_dleft[s]--;
            if (m_dleft[s] > 0) begin
                m_duty[s] = m;
                return;
            end
            m_last[s] = 0;
            m_mode[s] = want;
        end else if (want != 0 && m_last[s] != 0 && want != m_last[s]) begin
            m_mode[s]  = 3;
            m_dleft[s] = DEAD_PRDS;
        end else begin
            m_mode[s] = want;
        end
`else
        m_mode[s] = want;
`endif
        if (m_mode[s] == 1 || m_mode[s] == 2) m_last[s] = m_mode[s];
        m_duty[s] = m;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cnt = 0;
                e_prd = 0;
                for (int s = 0; s < 2; s++) begin
                    m_mode[s] = 0; m_duty[s] = 0; m_last[s] = 0;
                    e_fwd[s]  = 0; e_rev[s]  = 0;
`ifdef MTR_DEADTIME_EN
                    m_dleft[s] = 0;
`endif
                end
            end else begin
                e_prd = (m_cnt == 0) ? 1 : 0;
                for (int s = 0; s < 2; s++) begin
                    e_fwd[s] = (m_mode[s] == 1 && m_cnt < m_duty[s]) ? 1 : 0;
                    e_rev[s] = (m_mode[s] == 2 && m_cnt < m_duty[s]) ? 1 : 0;
                end
                if (m_cnt == PRD - 1) begin
                    plan(0, int'(lft_spd));
                    plan(1, int'(rght_spd));
                end
                m_cnt = (m_cnt + 1) % PRD;
            end
        end
    end

    // Per-cycle comparison against the model, plus the leg exclusivity invariant.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("lft_fwd",   int'(lft_fwd),  e_fwd[0]);
            check("lft_rev",   int'(lft_rev),  e_rev[0]);
            check("rght_fwd",  int'(rght_fwd), e_fwd[1]);
            check("rght_rev",  int'(rght_rev), e_rev[1]);
            check("prd_strt",  int'(prd_strt), e_prd);
            check("lft_excl",  int'(lft_fwd & lft_rev), 0);
            check("rght_excl", int'(rght_fwd & rght_rev), 0);
        end
    end

    // Align to a prd_strt cycle, then count leg highs over one full period; optionally
    // change the commands at sample index chg_at.
    task automatic measure(input int chg_at, input int c_en, input int c_l, input int c_r,
                           output int lf, output int lr, output int rf, output int rr);
        int guard;
        guard = 0;
        lf = 0; lr = 0; rf = 0; rr = 0;
        while (prd_strt !== 1'b1 && guard < 3 * PRD) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3 * PRD) check("prd_wait", 0, 1);
        for (int i = 0; i < PRD; i++) begin
            lf += int'(lft_fwd);
            lr += int'(lft_rev);
            rf += int'(rght_fwd);
            rr += int'(rght_rev);
            if (i == chg_at) begin
                en       = c_en[0];
                lft_spd  = 11'(c_l);
                rght_spd = 11'(c_r);
            end
            @(negedge clk);
        end
    endtask

    int spd_tab[8] = '{0, 1, 300, -300, 1023, -1024, 512, -1};

    initial begin
        int lf, lr, rf, rr;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_legs", int'(lft_fwd | lft_rev | rght_fwd | rght_rev), 0);
        check("rst_prd",  int'(prd_strt), 0);

        en = 1'b1; lft_spd = 11'sd256; rght_spd = -11'sd1024;
        rst = 1'b0;
        @(negedge clk);
        check("first_prd", int'(prd_strt), 1);

        // Period 0: nothing sampled yet.
        measure(-1, 1, 256, -1024, lf, lr, rf, rr);
        check("p0_lft_fwd", lf, 0);
        check("p0_rght_rev", rr, 0);

        // Period 1: 256 fwd left, clamped 1023 rev right; queue lft=300.
        measure(0, 1, 300, -1024, lf, lr, rf, rr);
        check("p1_lft_fwd", lf, 256);
        check("p1_lft_rev", lr, 0);
        check("p1_rght_fwd", rf, 0);
        check("p1_rght_rev", rr, 1023);

        // Period 2: 300 fwd; reversal to -300 requested mid-period.
        measure(100, 1, -300, -800, lf, lr, rf, rr);
        check("p2_lft_fwd", lf, 300);
        check("p2_lft_rev", lr, 0);
        check("p2_rght_rev", rr, 1023);

        // Period 3: dead gap or direct reversal.
        measure(-1, 1, -300, -800, lf, lr, rf, rr);
        check("p3_lft_fwd", lf, 0);
`ifdef MTR_DEADTIME_EN
        check("p3_lft_rev_dead", lr, 0);
`else
        check("p3_lft_rev", lr, 300);
`endif
        check("p3_rght_rev", rr, 800);

        // Period 4: en dropped mid-period; current duty still completes.
        measure(500, 0, -300, -800, lf, lr, rf, rr);
        check("p4_lft_rev", lr, 300);
        check("p4_rght_rev", rr, 800);

        // Period 5: disabled; then enable with zero speed.
        measure(0, 1, 0, 0, lf, lr, rf, rr);
        check("p5_off", lf + lr + rf + rr, 0);

        // Period 6: zero speed stays idle; queue lft=-256.
        measure(0, 1, -256, -1024, lf, lr, rf, rr);
        check("p6_zero", lf + lr + rf + rr, 0);

        // Period 7: reset asserted at count 600.
        lr = 0;
        for (int i = 0; i < 600; i++) begin
            lr += int'(lft_rev);
            @(negedge clk);
        end
        check("p7_lft_rev_600", lr, 256);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_legs", int'(lft_fwd | lft_rev | rght_fwd | rght_rev), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_prd", int'(prd_strt), 1);

        // Random commands, enables and occasional resets; model compare runs throughout.
        for (int k = 0; k < 8000; k++) begin
            if ($urandom_range(0, 99) < 3) lft_spd  = 11'(spd_tab[$urandom_range(0, 7)]);
            if ($urandom_range(0, 99) < 3) rght_spd = 11'(spd_tab[$urandom_range(0, 7)]);
            if ($urandom_range(0, 99) < 1) en = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 1999) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
